// File: rtl/hazard_scoreboard.sv
// Register scoreboard between ID and WB: per-register count of in-flight writers.
// Stalls issue on RAW hazards or counter saturation; entries release on WB retire or EX squash.
module hazard_scoreboard #(
   parameter int NUM_REGS  = 32,
   parameter int IDX_W     = $clog2(NUM_REGS),
   parameter int CNT_W     = 2,
   parameter bit WB_BYPASS = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                issue_valid_i,
   input  logic                issue_rd_wr_i,
   input  logic [IDX_W-1:0]    issue_rd_i,
   input  logic                issue_rs1_used_i,
   input  logic [IDX_W-1:0]    issue_rs1_i,
   input  logic                issue_rs2_used_i,
   input  logic [IDX_W-1:0]    issue_rs2_i,
   input  logic                retire_valid_i,
   input  logic [IDX_W-1:0]    retire_rd_i,
   input  logic                kill_valid_i,
   input  logic [IDX_W-1:0]    kill_rd_i,
   output logic                stall_o,
   output logic                issue_ack_o,
   output logic [NUM_REGS-1:0] pending_o,
   output logic                idle_o,
   output logic                err_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [NUM_REGS-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [NUM_REGS-1:0]            pending_q, pending_d;
   logic                           idle_q, idle_d;
   logic                           err_q, err_d;
   logic                           hz_rs1, hz_rs2, sat_rd, stall;
   logic [CNT_W:0]                 add_w, sub_w;
   logic                           underflow;

   // x0 and indices beyond NUM_REGS are never tracked.
   function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
      return (idx != '0) && (int'(idx) < NUM_REGS);
   endfunction

   function automatic logic hazard(input logic [IDX_W-1:0] r);
      logic bypass;
      bypass = WB_BYPASS && retire_valid_i && (retire_rd_i == r) && (cnt_q[r] == CNT_ONE);
      return idx_ok(r) && (cnt_q[r] != '0) && !bypass;
   endfunction

   // Saturation looks at the current count only; a same-cycle retire does not lift it.
   always_comb begin
      hz_rs1 = issue_rs1_used_i && hazard(issue_rs1_i);
      hz_rs2 = issue_rs2_used_i && hazard(issue_rs2_i);
      sat_rd = issue_rd_wr_i && idx_ok(issue_rd_i) && (cnt_q[issue_rd_i] == CNT_MAX);
      stall  = issue_valid_i && (hz_rs1 || hz_rs2 || sat_rd);
   end

   assign stall_o     = stall;
   assign issue_ack_o = issue_valid_i && !stall;

   // NOTE: every variable below gets a default before the loop so no path leaves it unassigned (no latches).
   always_comb begin
      cnt_d     = '0;
      pending_d = '0;
      underflow = 1'b0;
      add_w     = '0;
      sub_w     = '0;
      for (int r = 1; r < NUM_REGS; r++) begin
         add_w = {1'b0, cnt_q[r]}
               + (CNT_W+1)'(issue_ack_o && issue_rd_wr_i && (int'(issue_rd_i) == r));
         sub_w = (CNT_W+1)'(retire_valid_i && (int'(retire_rd_i) == r))
               + (CNT_W+1)'(kill_valid_i && (int'(kill_rd_i) == r));
         if (sub_w > add_w) begin
            underflow = 1'b1;
         end else begin
            cnt_d[r] = CNT_W'(add_w - sub_w);
         end
         pending_d[r] = (cnt_d[r] != '0);
      end
      idle_d = (pending_d == '0);
      err_d  = err_q || underflow;
   end

   // NOTE: the counter array is reset as a whole; a mid-run reset must discard every in-flight writer.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q     <= '0;
         pending_q <= '0;
         idle_q    <= 1'b1;
         err_q     <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         idle_q    <= idle_d;
         err_q     <= err_d;
      end
   end

   assign pending_o = pending_q;
   assign idle_o    = idle_q;
   assign err_o     = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: instance 0 with WB bypass, instance 1 without, same stimulus.
// A per-cycle integer model checks both; directed literal checks pin the model.
module tb_hazard_scoreboard;

   localparam int NUM_REGS = 32;
   localparam int IDX_W    = 5;
   localparam int CNT_MAX  = 3;

   logic clk = 1'b0;
   logic rst;
   logic iv, wr, u1, u2, rv, kv;
   logic [IDX_W-1:0] rd, s1, s2, rr, kr;

   logic [1:0]                stall_w, ack_w, idle_w, err_w;
   logic [1:0][NUM_REGS-1:0]  pend_w;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   hazard_scoreboard #(.NUM_REGS(NUM_REGS), .CNT_W(2), .WB_BYPASS(1'b1)) u_dut_bp (
      .clk(clk), .rst(rst),
      .issue_valid_i(iv), .issue_rd_wr_i(wr), .issue_rd_i(rd),
      .issue_rs1_used_i(u1), .issue_rs1_i(s1), .issue_rs2_used_i(u2), .issue_rs2_i(s2),
      .retire_valid_i(rv), .retire_rd_i(rr), .kill_valid_i(kv), .kill_rd_i(kr),
      .stall_o(stall_w[0]), .issue_ack_o(ack_w[0]), .pending_o(pend_w[0]),
      .idle_o(idle_w[0]), .err_o(err_w[0])
   );

   hazard_scoreboard #(.NUM_REGS(NUM_REGS), .CNT_W(2), .WB_BYPASS(1'b0)) u_dut_nb (
      .clk(clk), .rst(rst),
      .issue_valid_i(iv), .issue_rd_wr_i(wr), .issue_rd_i(rd),
      .issue_rs1_used_i(u1), .issue_rs1_i(s1), .issue_rs2_used_i(u2), .issue_rs2_i(s2),
      .retire_valid_i(rv), .retire_rd_i(rr), .kill_valid_i(kv), .kill_rd_i(kr),
      .stall_o(stall_w[1]), .issue_ack_o(ack_w[1]), .pending_o(pend_w[1]),
      .idle_o(idle_w[1]), .err_o(err_w[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model: integer counts per instance ----------------
   int m_cnt [2][NUM_REGS];
   bit m_err [2];
   bit m_live = 1'b0;

   function automatic bit m_hazard(int inst, int r);
      bit bypass;
      bypass = (inst == 0) && rv && (int'(rr) == r) && (m_cnt[inst][r] == 1);
      return (r != 0) && (m_cnt[inst][r] > 0) && !bypass;
   endfunction

   function automatic bit m_stall(int inst);
      if (!iv) return 1'b0;
      if (u1 && m_hazard(inst, int'(s1))) return 1'b1;
      if (u2 && m_hazard(inst, int'(s2))) return 1'b1;
      return wr && (rd != 0) && (m_cnt[inst][rd] == CNT_MAX);
   endfunction

   initial begin : compare
      int nxt [2][NUM_REGS];
      bit nerr [2];
      bit s_exp [2];
      logic [NUM_REGS-1:0] p_exp;
      int n;
      forever begin
         @(negedge clk);
         #2;
         for (int i = 0; i < 2; i++) begin
            s_exp[i] = m_stall(i);
            if (m_live) begin
               p_exp = '0;
               for (int r = 0; r < NUM_REGS; r++) p_exp[r] = (m_cnt[i][r] > 0);
               check($sformatf("model stall[%0d]", i), stall_w[i], s_exp[i]);
               check($sformatf("model ack[%0d]", i), ack_w[i], iv && !s_exp[i]);
               check($sformatf("model pending[%0d]", i), pend_w[i], p_exp);
               check($sformatf("model idle[%0d]", i), idle_w[i], p_exp == '0);
               check($sformatf("model err[%0d]", i), err_w[i], m_err[i]);
            end
            nerr[i] = m_err[i];
            nxt[i][0] = 0;
            for (int r = 1; r < NUM_REGS; r++) begin
               n = m_cnt[i][r];
               if (iv && !s_exp[i] && wr && int'(rd) == r) n++;
               if (rv && int'(rr) == r) n--;
               if (kv && int'(kr) == r) n--;
               if (n < 0) begin
                  n = 0;
                  nerr[i] = 1'b1;
               end
               nxt[i][r] = n;
            end
         end
         @(posedge clk);
         if (!rst) begin
            m_live = 1'b1;
            for (int i = 0; i < 2; i++) begin
               m_err[i] = 1'b0;
               for (int r = 0; r < NUM_REGS; r++) m_cnt[i][r] = 0;
            end
         end else begin
            for (int i = 0; i < 2; i++) begin
               m_err[i] = nerr[i];
               for (int r = 0; r < NUM_REGS; r++) m_cnt[i][r] = nxt[i][r];
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic set_in(input bit i_v, input bit i_wr, input int i_rd,
                         input bit i_u1, input int i_s1, input bit i_u2, input int i_s2,
                         input bit r_v, input int r_rd, input bit k_v, input int k_rd);
      iv = i_v;  wr = i_wr; rd = IDX_W'(i_rd);
      u1 = i_u1; s1 = IDX_W'(i_s1);
      u2 = i_u2; s2 = IDX_W'(i_s2);
      rv = r_v;  rr = IDX_W'(r_rd);
      kv = k_v;  kr = IDX_W'(k_rd);
   endtask

   task automatic step(input bit i_v, input bit i_wr, input int i_rd,
                       input bit i_u1, input int i_s1, input bit i_u2, input int i_s2,
                       input bit r_v, input int r_rd, input bit k_v, input int k_rd);
      @(negedge clk);
      set_in(i_v, i_wr, i_rd, i_u1, i_s1, i_u2, i_s2, r_v, r_rd, k_v, k_rd);
      #3;
   endtask

   task automatic nop();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic wr_issue(input int r);
      step(1, 1, r, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic retire(input int r);
      step(0, 0, 0, 0, 0, 0, 0, 1, r, 0, 0);
   endtask

   task automatic rand_in();
      set_in(1'($urandom), 1'($urandom), int'($urandom_range(31)), 1'($urandom),
             int'($urandom_range(31)), 1'($urandom), int'($urandom_range(31)),
             1'($urandom), int'($urandom_range(31)), 1'($urandom), int'($urandom_range(31)));
   endtask

   initial begin
      rst = 1'b0;
      rand_in();
      @(negedge clk);
      rand_in();
      @(negedge clk);
      rst = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #3;
      check("reset pending", pend_w[0], 32'h0);
      check("reset idle", idle_w[0], 1);
      check("reset err", err_w[0], 0);
      check("reset stall", stall_w[0], 0);

      // RAW on rs1 with and without WB bypass
      wr_issue(5);
      check("raw first ack", ack_w[0], 1);
      step(1, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0);
      check("raw pending5", pend_w[0][5], 1);
      check("raw stall bp", stall_w[0], 1);
      check("raw stall nb", stall_w[1], 1);
      step(1, 0, 0, 1, 5, 0, 0, 1, 5, 0, 0);
      check("raw bypass stall", stall_w[0], 0);
      check("raw bypass ack", ack_w[0], 1);
      check("raw nobypass stall", stall_w[1], 1);
      step(1, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0);
      check("raw nobypass late", stall_w[1], 0);
      check("raw pending5 clear", pend_w[0][5], 0);

      // rs2 hazard at count 2: retire does not bypass until count 1
      wr_issue(8);
      wr_issue(8);
      step(1, 0, 0, 0, 8, 0, 8, 0, 0, 0, 0);
      check("unused srcs no stall", stall_w[0], 0);
      step(1, 0, 0, 0, 8, 1, 8, 1, 8, 0, 0);
      check("rs2 cnt2 stall", stall_w[0], 1);
      step(1, 0, 0, 0, 8, 1, 8, 1, 8, 0, 0);
      check("rs2 cnt1 bypass", stall_w[0], 0);
      check("rs2 cnt1 nobypass", stall_w[1], 1);
      nop();
      check("rs2 idle", idle_w[0], 1);

      // Saturation on x7
      wr_issue(7);
      wr_issue(7);
      wr_issue(7);
      check("sat third ack", ack_w[0], 1);
      step(1, 1, 7, 0, 0, 0, 0, 1, 7, 0, 0);
      check("sat fourth stall", stall_w[0], 1);
      check("sat fourth ack", ack_w[0], 0);
      wr_issue(7);
      check("sat retry ack", ack_w[0], 1);
      retire(7);
      retire(7);
      retire(7);
      nop();
      check("sat drained idle", idle_w[0], 1);

      // Issue + retire + kill on x9 in one cycle
      wr_issue(9);
      wr_issue(9);
      step(1, 1, 9, 0, 0, 0, 0, 1, 9, 1, 9);
      check("simul ack", ack_w[0], 1);
      nop();
      check("simul pending9", pend_w[0], 32'h0000_0200);
      check("simul err", err_w[0], 0);
      retire(9);

      // Retire and kill to different registers
      wr_issue(10);
      wr_issue(11);
      step(0, 0, 0, 0, 0, 0, 0, 1, 10, 1, 11);
      nop();
      check("split idle", idle_w[0], 1);

      // x0 is ignored everywhere
      step(1, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0);
      check("x0 stall", stall_w[0], 0);
      check("x0 ack", ack_w[0], 1);
      nop();
      check("x0 pending", pend_w[0], 32'h0);
      check("x0 err", err_w[0], 0);

      // Flush: kill + retire clears two writers
      wr_issue(4);
      wr_issue(4);
      step(0, 0, 0, 0, 0, 0, 0, 1, 4, 1, 4);
      nop();
      check("flush idle", idle_w[0], 1);
      check("flush pending", pend_w[0], 32'h0);

      // Underflow is sticky until reset
      retire(3);
      nop();
      check("underflow err bp", err_w[0], 1);
      check("underflow err nb", err_w[1], 1);
      wr_issue(12);
      nop();
      nop();
      check("err sticky", err_w[0], 1);
      check("pending12", pend_w[0], 32'h0000_1000);

      // Mid-operation reset discards state
      @(negedge clk);
      rst = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      #3;
      check("midreset pending", pend_w[0], 32'h0);
      check("midreset idle", idle_w[0], 1);
      check("midreset err", err_w[0], 0);
      nop();
      nop();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
